// File: rtl/range_pkg.sv
// Shared definitions for the echo range meter.
//
// Contents:
//   state_t    - measurement FSM states
//   RANGE_W    - width of a range value in centimetres
//   MAX_RANGE  - saturated / "no measurement" range value
//   AVG_DEPTH  - number of samples in the averaging history (RANGE_AVG_EN builds)
//   AVG_SHIFT  - log2(AVG_DEPTH), turns the history sum into a mean
//   SUM_W      - width of the history sum
package range_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } state_t;

    localparam int RANGE_W = 10;
    localparam logic [RANGE_W-1:0] MAX_RANGE = 10'h3FF;

    localparam int AVG_DEPTH = 4;
    localparam int AVG_SHIFT = $clog2(AVG_DEPTH);
    localparam int SUM_W     = RANGE_W + AVG_SHIFT;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the asynchronous sensor echo, followed by an
// edge detector that works on the synchronized level only.
//
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset, clears all flops
//   i_echo  - raw asynchronous echo from the sensor
//   level   - synchronized echo level
//   rise    - one-cycle pulse on a synchronized 0->1 transition
//   fall    - one-cycle pulse on a synchronized 1->0 transition
module echo_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_echo,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // meta/sync form the synchronizer; prev is the previous synchronized
    // level used only for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= i_echo;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/echo_range_meter.sv
// Ultrasonic echo range meter. Periodically fires a trigger pulse, times the
// high period of the returned echo and converts it to centimetres.
//
// Build option: define RANGE_AVG_EN to report the mean of the last AVG_DEPTH
// raw samples instead of the raw sample itself.
//
// Ports:
//   i_clk     - clock, all logic on the rising edge
//   i_rst_n   - asynchronous active-low reset
//   i_echo    - asynchronous sensor echo
//   o_trig    - sensor trigger pulse, TRIG_CYCLES wide
//   o_range   - distance in cm (MAX_RANGE after reset or on echo timeout)
//   o_valid   - one-cycle strobe when o_range updates
//   o_timeout - one-cycle strobe when a wait or a measurement times out
module echo_range_meter
    import range_pkg::*;
#(
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int PERIOD_CYCLES  = 3_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_echo,
    output logic               o_trig,
    output logic [RANGE_W-1:0] o_range,
    output logic               o_valid,
    output logic               o_timeout
);

    localparam int PHASE_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int PERIOD_W  = $clog2(PERIOD_CYCLES + 1);
    localparam int PRE_W     = $clog2(CYCLES_PER_CM + 1);

    localparam logic [PHASE_W-1:0]  TRIG_LAST   = PHASE_W'(TRIG_CYCLES - 1);
    localparam logic [PHASE_W-1:0]  TMO_LAST    = PHASE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PERIOD_CYCLES - 1);
    localparam logic [PRE_W-1:0]    PRE_LAST    = PRE_W'(CYCLES_PER_CM - 1);

    // The cycle that detects the rise already saw echo high, so it is counted
    // as the first high clock when the prescaler is loaded.
    localparam logic [PRE_W-1:0]   PRE_ENTRY = (CYCLES_PER_CM == 1) ? '0 : PRE_W'(1);
    localparam logic [RANGE_W-1:0] CM_ENTRY  = (CYCLES_PER_CM == 1) ? RANGE_W'(1) : '0;

    state_t state;
    state_t next_state;

    logic [PHASE_W-1:0]  phase_cnt;
    logic [PERIOD_W-1:0] period_cnt;
    logic [PRE_W-1:0]    pre_cnt;
    logic [RANGE_W-1:0]  cm_cnt;

    logic echo_level;
    logic echo_rise;
    logic echo_fall;

    logic wait_tmo;
    logic meas_done;
    logic meas_tmo;
    logic sample_en;
    logic [RANGE_W-1:0] raw_sample;
    logic [RANGE_W-1:0] range_next;

    echo_sync u_echo_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_echo  (i_echo),
        .level   (echo_level),
        .rise    (echo_rise),
        .fall    (echo_fall)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A falling edge beats a timeout that lands in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      next_state = ST_TRIG;
            ST_TRIG:      if (phase_cnt == TRIG_LAST) next_state = ST_WAIT_RISE;
            ST_WAIT_RISE: begin
                if (echo_rise)                  next_state = ST_MEASURE;
                else if (phase_cnt == TMO_LAST) next_state = ST_HOLDOFF;
            end
            ST_MEASURE: begin
                if (echo_fall)                  next_state = ST_HOLDOFF;
                else if (phase_cnt == TMO_LAST) next_state = ST_HOLDOFF;
            end
            ST_HOLDOFF:   if (period_cnt == PERIOD_LAST) next_state = ST_TRIG;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_trig    = (state == ST_TRIG);
        wait_tmo  = 1'b0;
        meas_done = 1'b0;
        meas_tmo  = 1'b0;
        case (state)
            ST_WAIT_RISE: wait_tmo = !echo_rise && (phase_cnt == TMO_LAST);
            ST_MEASURE: begin
                meas_done = echo_fall;
                meas_tmo  = !echo_fall && (phase_cnt == TMO_LAST);
            end
            default: ;
        endcase
    end

    // phase_cnt times the current state from 0; period_cnt runs from the first
    // trigger cycle and parks at its last value so a long measurement cannot
    // wrap it past the holdoff compare.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_cnt  <= '0;
            period_cnt <= '0;
        end else begin
            phase_cnt <= (next_state != state) ? '0 : phase_cnt + 1'b1;
            if (next_state == ST_TRIG && state != ST_TRIG) begin
                period_cnt <= '0;
            end else if (period_cnt != PERIOD_LAST) begin
                period_cnt <= period_cnt + 1'b1;
            end
        end
    end

    // Prescaler divides echo-high clocks into whole centimetres; the
    // remainder is simply dropped when the measurement ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_cnt <= '0;
            cm_cnt  <= '0;
        end else if (state == ST_WAIT_RISE && echo_rise) begin
            pre_cnt <= PRE_ENTRY;
            cm_cnt  <= CM_ENTRY;
        end else if (state == ST_MEASURE && echo_level) begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
                if (cm_cnt != MAX_RANGE) cm_cnt <= cm_cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    assign sample_en  = meas_done | meas_tmo;
    assign raw_sample = meas_done ? cm_cnt : MAX_RANGE;

`ifdef RANGE_AVG_EN
    logic [RANGE_W-1:0] hist [AVG_DEPTH];
    logic [SUM_W-1:0]   hist_sum;

    // Sum of the history as it will look after this sample shifts in:
    // everything currently held, minus the oldest entry, plus the new sample.
    always_comb begin
        hist_sum = SUM_W'(raw_sample);
        for (int i = 0; i < AVG_DEPTH; i++) begin
            hist_sum = hist_sum + SUM_W'(hist[i]);
        end
        hist_sum = hist_sum - SUM_W'(hist[AVG_DEPTH-1]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < AVG_DEPTH; i++) hist[i] <= MAX_RANGE;
        end else if (sample_en) begin
            hist[0] <= raw_sample;
            for (int i = 1; i < AVG_DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    assign range_next = hist_sum[SUM_W-1:AVG_SHIFT];
`else
    assign range_next = raw_sample;
`endif

    // Result and strobes are registered together so o_valid always coincides
    // with the new o_range value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_range   <= MAX_RANGE;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_valid   <= sample_en;
            o_timeout <= wait_tmo | meas_tmo;
            if (sample_en) o_range <= range_next;
        end
    end

endmodule

// File: tb/tb_echo_range_meter.sv
// Self-checking bench for echo_range_meter with small timing parameters.
// Each table entry drives one echo pulse (length 0 = no echo) a few clocks
// after the trigger ends and states the expected raw range, which strobes
// fire, and when they fire relative to the trigger falling. Expected o_range
// goes through a bench-side history model when RANGE_AVG_EN is defined.
module tb_echo_range_meter;

    localparam int TRIG   = 4;
    localparam int CPC    = 10;
    localparam int TMO    = 1000;
    localparam int PERIOD = 2000;
    localparam int WINDOW = 1990;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_echo;
    logic       o_trig;
    logic [9:0] o_range;
    logic       o_valid;
    logic       o_timeout;

    int cyc = 0;
    int n_compared = 0;
    int n_mismatched = 0;
    int trig_start = 0;
    int prev_range = 1023;
    int model_hist [4];

    typedef struct {
        int echo_len;
        int exp_raw;
        bit exp_valid;
        bit exp_tmo;
        int exp_t;
    } vec_t;

    vec_t vecs [9];

    echo_range_meter #(
        .TRIG_CYCLES    (TRIG),
        .CYCLES_PER_CM  (CPC),
        .TIMEOUT_CYCLES (TMO),
        .PERIOD_CYCLES  (PERIOD)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_echo    (i_echo),
        .o_trig    (o_trig),
        .o_range   (o_range),
        .o_valid   (o_valid),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic resetModel();
        prev_range = 1023;
        for (int i = 0; i < 4; i++) model_hist[i] = 1023;
    endtask

    task automatic computeExpected(input int raw, output int exp_range);
`ifdef RANGE_AVG_EN
        int sum;
        for (int i = 3; i > 0; i--) model_hist[i] = model_hist[i-1];
        model_hist[0] = raw;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += model_hist[i];
        exp_range = sum / 4;
`else
        exp_range = raw;
`endif
    endtask

    // Waits for the next trigger, checks its start against ref_cyc + delay,
    // its width, and that no strobe appears meanwhile.
    task automatic awaitTrig(input int ref_cyc, input int exp_delay, input string name);
        int found = 0;
        int strobes = 0;
        for (int i = 0; i < exp_delay + 50 && found == 0; i++) begin
            @(negedge i_clk);
            if (o_valid || o_timeout) strobes++;
            if (o_trig) found = 1;
        end
        if (found == 0) begin
            checkOutput({name, " trig start"}, -1, exp_delay);
            return;
        end
        checkOutput({name, " trig start"}, cyc - ref_cyc, exp_delay);
        trig_start = cyc;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge i_clk);
            if (o_valid || o_timeout) strobes++;
            if (!o_trig) found = 1;
        end
        checkOutput({name, " trig width"}, found ? cyc - trig_start : -1, TRIG);
        checkOutput({name, " strobes around trig"}, strobes, 0);
    endtask

    // Called on the negedge where o_trig is first seen low (t = 0).
    task automatic applyStimulus(input vec_t v, input int idx);
        int n_valid = 0;
        int n_tmo = 0;
        int valid_t = -1;
        int tmo_t = -1;
        int range_at = -1;
        int exp_range;
        string tag;
        tag = $sformatf("v%0d(len %0d)", idx, v.echo_len);
        fork
            begin
                if (v.echo_len > 0) begin
                    repeat (5) @(negedge i_clk);
                    i_echo = 1'b1;
                    repeat (v.echo_len) @(negedge i_clk);
                    i_echo = 1'b0;
                end
            end
            begin
                for (int t = 1; t <= WINDOW; t++) begin
                    @(negedge i_clk);
                    if (o_valid) begin
                        n_valid++;
                        if (valid_t < 0) begin
                            valid_t = t;
                            range_at = int'(o_range);
                        end
                    end
                    if (o_timeout) begin
                        n_tmo++;
                        if (tmo_t < 0) tmo_t = t;
                    end
                end
            end
        join
        if (v.exp_valid) computeExpected(v.exp_raw, exp_range);
        else exp_range = prev_range;
        checkOutput({tag, " valid count"}, n_valid, v.exp_valid ? 1 : 0);
        checkOutput({tag, " timeout count"}, n_tmo, v.exp_tmo ? 1 : 0);
        if (v.exp_valid) begin
            checkOutput({tag, " valid time"}, valid_t, v.exp_t);
            checkOutput({tag, " range at valid"}, range_at, exp_range);
        end
        if (v.exp_tmo) checkOutput({tag, " timeout time"}, tmo_t, v.exp_t);
        checkOutput({tag, " range held"}, int'(o_range), exp_range);
        prev_range = exp_range;
    endtask

    initial begin
        // len, raw cm, valid, timeout, strobe time after trig fall
        vecs[0] = '{250,  25,   1'b1, 1'b0, 258};
        vecs[1] = '{259,  25,   1'b1, 1'b0, 267};
        vecs[2] = '{10,   1,    1'b1, 1'b0, 18};
        vecs[3] = '{9,    0,    1'b1, 1'b0, 17};
        vecs[4] = '{0,    0,    1'b0, 1'b1, 1000};
        vecs[5] = '{1000, 100,  1'b1, 1'b0, 1008};
        vecs[6] = '{1001, 1023, 1'b1, 1'b1, 1008};
        vecs[7] = '{1500, 1023, 1'b1, 1'b1, 1008};
        vecs[8] = '{123,  12,   1'b1, 1'b0, 131};

        resetModel();
        i_rst_n = 1'b0;
        i_echo  = 1'b0;
        repeat (3) @(negedge i_clk);
        checkOutput("reset o_trig", int'(o_trig), 0);
        checkOutput("reset o_range", int'(o_range), 1023);
        checkOutput("reset o_valid", int'(o_valid), 0);
        checkOutput("reset o_timeout", int'(o_timeout), 0);

        i_rst_n = 1'b1;
        awaitTrig(cyc, 1, "post-reset");
        checkOutput("post-reset o_range", int'(o_range), 1023);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], i);
            awaitTrig(trig_start, PERIOD, $sformatf("after v%0d", i));
        end

        // Reset in the middle of a measurement: outputs clear at once, no
        // strobe for the aborted echo, fresh trigger after release.
        $display("[TB] reset during measurement");
        repeat (5) @(negedge i_clk);
        i_echo = 1'b1;
        repeat (150) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checkOutput("mid-reset o_trig", int'(o_trig), 0);
        checkOutput("mid-reset o_range", int'(o_range), 1023);
        checkOutput("mid-reset o_valid", int'(o_valid), 0);
        checkOutput("mid-reset o_timeout", int'(o_timeout), 0);
        i_echo = 1'b0;
        repeat (3) @(negedge i_clk);
        resetModel();
        i_rst_n = 1'b1;
        awaitTrig(cyc, 1, "after mid-reset");
        checkOutput("after mid-reset o_range", int'(o_range), 1023);
        applyStimulus(vecs[0], 9);
        awaitTrig(trig_start, PERIOD, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
